// File: rtl/jtvigil_pkg.sv
// jtvigil_pkg: register map, control bit positions and SCR2 fetch FSM encoding
// shared by the Vigilante video blocks.
package jtvigil_pkg;
    localparam logic [1:0] SCR2_SCRL_LO = 2'd0;
    localparam logic [1:0] SCR2_SCRL_HI = 2'd1;
    localparam logic [1:0] SCR2_CTRL    = 2'd2;
    localparam int CTRL_COL_MSB = 2;
    localparam int CTRL_COL_LSB = 0;
    localparam int CTRL_ENB     = 6;
    typedef enum logic [2:0] { IDLE, FETCH, WAIT, PRESHIFT, RUN } scr2_st_e;
endpackage

// File: rtl/jtvigil_scr2_shift.sv
// jtvigil_scr2_shift: two-word pixel buffer; the lower word feeds pixels out four bits
// at a time and the upper word drops into its place once eight pixels have gone.
module jtvigil_scr2_shift (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        ld,
    input  logic        shift,
    input  logic [31:0] data,
    output logic [3:0]  pxl,
    output logic        lo_vld,
    output logic        hi_vld
);
    logic [63:0] sr, sr_n;
    logic [1:0]  vld, vld_n;
    logic [2:0]  cnt, cnt_n;
    logic        ld_lo, ld_hi, sh, drop, vhi;
    logic [31:0] hi;

    // a load always fills whichever half is empty, lower first
    always_comb begin
        ld_lo = ld & ~vld[0];
        ld_hi = ld & vld[0];
        sh    = shift & vld[0];
        drop  = sh & (cnt == 3'd7);
        hi    = ld_hi ? data : sr[63:32];
        vhi   = vld[1] | ld_hi;
        sr_n  = drop ? {32'd0, hi} :
                sh ? {hi, 4'd0, sr[31:4]} :
                ld_lo ? {sr[63:32], data} : {hi, sr[31:0]};
        vld_n = drop ? {1'b0, vhi} : {vhi, vld[0] | ld_lo};
        cnt_n = drop ? 3'd0 : cnt + {2'd0, sh};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sr  <= '0;
            vld <= '0;
            cnt <= '0;
        end else begin
            sr  <= clr ? '0 : sr_n;
            vld <= clr ? '0 : vld_n;
            cnt <= clr ? '0 : cnt_n;
        end

    assign pxl    = sr[3:0];
    assign lo_vld = vld[0];
    assign hi_vld = vld[1];
endmodule

// File: rtl/jtvigil_scr2.sv
// jtvigil_scr2: Vigilante rear background layer; scrolls a 2048x256 4bpp ROM bitmap
// and streams one pixel per pxl_cen to the colour mixer.
module jtvigil_scr2
    import jtvigil_pkg::*;
#(
    parameter int SCRW = 11,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic [8:0]    v,
    input  logic [1:0]    cpu_addr,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_we,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [31:0]   rom_data,
    input  logic          rom_ok,
    output logic [3:0]    scr2_pxl,
    output logic [2:0]    scr2col,
    output logic          scr2enb,
    output logic          underrun
);
    logic [SCRW-1:0] scroll, scroll_nx;
    logic [SCRW-4:0] col;
    logic [7:0]      row;
    logic [2:0]      fine;
    logic [3:0]      pxl;
    logic            lhbl_l, line_start, ld, shift, pxl_sh, lo_vld, hi_vld, prime, run_ok;
    logic            wr_lo, wr_hi, unused_v;
    scr2_st_e        st;

    // a write landing on the line-start clk must already be visible to the latch
    assign wr_lo      = cpu_we && cpu_addr == SCR2_SCRL_LO;
    assign wr_hi      = cpu_we && cpu_addr == SCR2_SCRL_HI;
    assign scroll_nx  = {wr_hi ? cpu_dout[SCRW-9:0] : scroll[SCRW-1:8], wr_lo ? cpu_dout : scroll[7:0]};
    assign line_start = lhbl_l & ~LHBL;
    assign ld         = st == WAIT && rom_ok && !line_start;
    assign pxl_sh     = pxl_cen && LHBL && run_ok && lo_vld;
    assign shift      = pxl_sh || (st == PRESHIFT && fine != 3'd0 && !line_start);
    assign unused_v   = v[8];

    jtvigil_scr2_shift u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (line_start),
        .ld     (ld),
        .shift  (shift),
        .data   (rom_data),
        .pxl    (pxl),
        .lo_vld (lo_vld),
        .hi_vld (hi_vld)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            scroll  <= '0;
            scr2col <= '0;
            scr2enb <= 1'b0;
        end else begin
            scroll <= scroll_nx;
            if (cpu_we && cpu_addr == SCR2_CTRL) begin
                scr2col <= cpu_dout[CTRL_COL_MSB:CTRL_COL_LSB];
                scr2enb <= cpu_dout[CTRL_ENB];
            end
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st       <= IDLE;
            lhbl_l   <= 1'b0;
            row      <= '0;
            col      <= '0;
            fine     <= '0;
            prime    <= 1'b0;
            run_ok   <= 1'b0;
            rom_addr <= '0;
            rom_cs   <= 1'b0;
            scr2_pxl <= '0;
            underrun <= 1'b0;
        end else begin
            lhbl_l   <= LHBL;
            scr2_pxl <= !LHBL ? 4'd0 : pxl_cen ? (pxl_sh ? pxl : 4'd0) : scr2_pxl;
            if (pxl_cen && LHBL && run_ok && !lo_vld) underrun <= 1'b1;
            if (line_start) begin
                row    <= v[7:0] + 8'd1;
                col    <= scroll_nx[SCRW-1:3];
                fine   <= scroll_nx[2:0];
                prime  <= 1'b1;
                run_ok <= 1'b0;
                rom_cs <= 1'b0;
                st     <= FETCH;
            end else begin
                case (st)
                    FETCH: begin
                        rom_addr <= {row, col};
                        rom_cs   <= 1'b1;
                        st       <= WAIT;
                    end
                    WAIT: if (rom_ok) begin
                        rom_cs <= 1'b0;
                        col    <= col + 1'b1;
                        if (prime && !lo_vld) st <= FETCH;
                        else if (prime) begin
                            prime  <= 1'b0;
                            run_ok <= fine == 3'd0;
                            st     <= fine == 3'd0 ? RUN : PRESHIFT;
                        end else st <= RUN;
                    end
                    PRESHIFT: if (fine == 3'd0) begin
                        run_ok <= 1'b1;
                        st     <= RUN;
                    end else fine <= fine - 3'd1;
                    RUN: if (!hi_vld) st <= FETCH;
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_jtvigil_scr2.sv
// tb_jtvigil_scr2: directed scan lines against a pixel-level bitmap model; pixel h of a
// line is bitmap[(scroll + h) mod 2048] on row v+1, checked on every clk.
`timescale 1ns/1ps
module tb_jtvigil_scr2;
    localparam int BLK = 48;
    localparam int ACT = 32;

    logic        clk = 0, rst_n = 0, pxl_cen = 0, LHBL = 1, cpu_we = 0;
    logic [8:0]  v = 0;
    logic [1:0]  cpu_addr = 0;
    logic [7:0]  cpu_dout = 0;
    logic [15:0] rom_addr;
    logic        rom_cs, rom_ok, scr2enb, underrun;
    logic [31:0] rom_data;
    logic [3:0]  scr2_pxl;
    logic [2:0]  scr2col;

    int          checks = 0, fails = 0, lat = 0, age = 0, hcnt = 0;
    bit          chk_en = 0;
    logic [15:0] prev = 0;
    logic [15:0] fq[$];
    logic [10:0] scroll_m = 0, scroll_w, line_scroll = 0;
    logic [7:0]  line_row = 0;
    logic [3:0]  exp_pxl = 0;
    logic        lhbl_d = 0;

    always #5 clk = ~clk;

    jtvigil_scr2 dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .v(v),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .scr2_pxl(scr2_pxl), .scr2col(scr2col), .scr2enb(scr2enb), .underrun(underrun)
    );

    function automatic logic [31:0] word(input logic [7:0] r, input logic [7:0] c);
        if (r == 8'd10 && c == 8'd0) return 32'h76543210;
        if (r == 8'd10 && c == 8'd1) return 32'hFEDCBA98;
        return {r, c, ~r, c ^ 8'h5A};
    endfunction

    function automatic logic [3:0] pix(input logic [10:0] x, input logic [7:0] r);
        return 4'(word(r, x[10:3]) >> (4 * x[2:0]));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    // ROM: data follows the address; ok once the address has been stable lat clks
    assign rom_data = word(rom_addr[15:8], rom_addr[7:0]);
    assign rom_ok   = rom_cs && rom_addr == prev && age >= lat;
    always @(posedge clk) begin
        prev <= rom_addr;
        age  <= (rom_cs && rom_addr == prev) ? age + 1 : 0;
        if (rom_cs && rom_ok) fq.push_back(rom_addr);
    end

    assign scroll_w = {(cpu_we && cpu_addr == 2'd1) ? cpu_dout[2:0] : scroll_m[10:8],
                       (cpu_we && cpu_addr == 2'd0) ? cpu_dout : scroll_m[7:0]};

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            scroll_m <= 0; lhbl_d <= 0; exp_pxl <= 0; hcnt <= 0; line_scroll <= 0; line_row <= 0;
        end else begin
            scroll_m <= scroll_w;
            lhbl_d   <= LHBL;
            if (lhbl_d && !LHBL) begin
                line_scroll <= scroll_w;
                line_row    <= 8'(v + 9'd1);
            end
            if (!LHBL) begin
                exp_pxl <= 0;
                hcnt    <= 0;
            end else if (pxl_cen) begin
                exp_pxl <= pix(11'(line_scroll + 11'(hcnt)), line_row);
                hcnt    <= hcnt + 1;
            end
        end

    always @(negedge clk) if (chk_en) check("pxl", {28'd0, scr2_pxl}, {28'd0, exp_pxl});

    task automatic line(input logic [8:0] vv, input bit chk);
        v = vv;
        for (int c = 0; c < BLK + ACT * 4; c++) begin
            @(negedge clk);
            LHBL    = c >= BLK;
            pxl_cen = c % 4 == 0;
            if (c == 1) fq.delete();
            if (c == 2) chk_en = chk;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_dout = d; cpu_we = 1;
        @(negedge clk);
        cpu_we = 0;
    endtask

    task automatic chk_fetch(input logic [15:0] a0, input logic [15:0] a1);
        check("nfetch", 32'(fq.size() >= 2), 1);
        if (fq.size() >= 2) begin
            check("fetch0", {16'd0, fq[0]}, {16'd0, a0});
            check("fetch1", {16'd0, fq[1]}, {16'd0, a1});
        end
    endtask

    task automatic chk_reset;
        check("rst_cs", {31'd0, rom_cs}, 0);
        check("rst_addr", {16'd0, rom_addr}, 0);
        check("rst_pxl", {28'd0, scr2_pxl}, 0);
        check("rst_col", {29'd0, scr2col}, 0);
        check("rst_enb", {31'd0, scr2enb}, 0);
        check("rst_und", {31'd0, underrun}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset();
        rst_n = 1;
        check("pin_p0", pix(11'd0, 8'd10), 4'h0);
        check("pin_p15", pix(11'd15, 8'd10), 4'hF);
        check("pin_p5", pix(11'd5, 8'd10), 4'h5);
        check("pin_p2044", pix(11'd2044, 8'd10), 4'hF);
        check("pin_p2047", pix(11'd2047, 8'd10), 4'h0);

        line(9'd9, 1);
        chk_fetch(16'h0A00, 16'h0A01);
        wr(2'd0, 8'h05);
        line(9'd9, 1);
        chk_fetch(16'h0A00, 16'h0A01);
        wr(2'd0, 8'hFC);
        wr(2'd1, 8'h07);
        line(9'd9, 1);
        chk_fetch(16'h0AFF, 16'h0A00);

        fork
            line(9'd20, 1);
            begin
                repeat (BLK + 40) @(negedge clk);
                wr(2'd0, 8'h10);
                wr(2'd1, 8'h00);
            end
        join
        chk_fetch(16'h15FF, 16'h1500);
        line(9'd21, 1);
        chk_fetch(16'h1602, 16'h1603);

        wr(2'd2, 8'h45);
        check("col45", {29'd0, scr2col}, 5);
        check("enb45", {31'd0, scr2enb}, 1);
        wr(2'd3, 8'hFF);
        check("col_a3", {29'd0, scr2col}, 5);
        check("enb_a3", {31'd0, scr2enb}, 1);
        wr(2'd2, 8'h02);
        check("col02", {29'd0, scr2col}, 2);
        check("enb02", {31'd0, scr2enb}, 0);

        fork
            line(9'd100, 1);
            wr(2'd0, 8'h33);
        join
        chk_fetch(16'h6506, 16'h6507);
        line(9'd255, 1);
        chk_fetch(16'h0006, 16'h0007);

        wr(2'd0, 8'h00);
        check("und_pre", {31'd0, underrun}, 0);
        fork
            line(9'd9, 1);
            begin
                repeat (BLK + 40) @(negedge clk);
                lat = 40;
                chk_en = 0;
            end
        join
        lat = 0;
        check("und_set", {31'd0, underrun}, 1);
        line(9'd9, 1);
        check("und_sticky", {31'd0, underrun}, 1);
        chk_fetch(16'h0A00, 16'h0A01);

        chk_en = 0;
        lat = 40;
        @(negedge clk);
        LHBL = 0;
        repeat (4) @(negedge clk);
        check("cs_pre", {31'd0, rom_cs}, 1);
        #1 rst_n = 0;
        #1 chk_reset();
        repeat (3) @(negedge clk);
        rst_n = 1; LHBL = 1; lat = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            pxl_cen = c % 4 == 0;
            check("cs_idle", {31'd0, rom_cs}, 0);
            check("pxl_idle", {28'd0, scr2_pxl}, 0);
        end
        pxl_cen = 0;
        line(9'd9, 1);
        chk_fetch(16'h0A00, 16'h0A01);
        chk_en = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/jtvigil_scr2.md
Name: jtvigil_scr2

Overview:
- Rear background (SCR2) pixel generator for Vigilante.
- Scrolls a 2048×256, 4bpp bitmap held in graphics ROM horizontally and streams one pixel per pxl_cen.
- Feeds scr2_pxl, scr2col and scr2enb to the colour mixer directly downstream.
- Holds the three CPU-written rear-layer registers and runs a prefetching ROM fetch engine with a two-word shift buffer.

Parameters:
- SCRW, 11, width of the horizontal scroll register (bitmap width 2^SCRW pixels).
- AW, 16, ROM word address width ({row[7:0], column[7:0]}).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pxl_cen  input  1  pixel clock enable.
- LHBL  input  1  active-low horizontal blank.
- v  input  9  current scan line.
- cpu_addr  input  2  register select.
- cpu_dout  input  8  CPU write data.
- cpu_we  input  1  register write strobe, one clk wide.
- rom_addr  output  16  ROM word address.
- rom_cs  output  1  ROM request.
- rom_data  input  32  ROM word: 8 pixels, pixel 0 in [3:0], pixel 7 in [31:28].
- rom_ok  input  1  rom_data valid for the current rom_addr.
- scr2_pxl  output  4  pixel colour index.
- scr2col  output  3  palette bank.
- scr2enb  output  1  rear layer disable; colmix shows SCR1 when high.
- underrun  output  1  sticky debug flag.

Behaviour:
- Reset: all registers, outputs, shift buffer and state are cleared to 0. rom_cs=0, rom_addr=0, scr2_pxl=0, scr2col=0, scr2enb=0, underrun=0. FSM enters IDLE. Reset asserted mid-line aborts any pending fetch immediately.
- Registers (write only, effective on the clk where cpu_we=1):
  - addr 0: scroll[7:0].
  - addr 1: scroll[10:8] from cpu_dout[2:0].
  - addr 2: scr2col from cpu_dout[2:0]; scr2enb from cpu_dout[6].
  - addr 3: ignored.
- Scroll is sampled into a line copy only at the LHBL falling edge, so mid-line writes affect the next line. scr2col and scr2enb update their outputs immediately.
- Line start (LHBL 1→0, detected on clk):
  - Latch row = v[7:0]+1, with 8-bit wrap: 255→0.
  - Latch col = scroll[10:3] and fine = scroll[2:0].
  - Clear the buffer-valid bits and go to FETCH.
- FSM states: IDLE, FETCH, WAIT, PRESHIFT, RUN.
  - FETCH: rom_addr={row,col}, rom_cs=1 → WAIT.
  - WAIT: hold rom_addr and rom_cs until rom_ok=1. Then write rom_data into the empty half of the 64-bit buffer and set col=col+1 (8-bit wrap 255→0, i.e. pixel 2047→0).
    - If the first fill: → FETCH.
    - If the second fill at line start: → PRESHIFT.
    - Otherwise → RUN.
  - PRESHIFT: discard one pixel (shift 4 bits) per clk, fine times; fine=0 takes zero cycles. → RUN. Must complete within HBLANK; the line budget allows ≥64 clk.
  - RUN:
    - rom_cs=0.
    - Each pxl_cen with LHBL=1 shifts out one pixel.
    - When 8 pixels of the lower word have been consumed, the upper word drops down and FSM → FETCH for the next word.
    - LHBL falling edge from any state restarts the line sequence.
- Output timing: scr2_pxl is registered. The pixel for screen column h is presented on the pxl_cen following the one where LHBL first rose, plus h pxl_cen; latency is one pxl_cen.
- During LHBL=0, scr2_pxl holds 0.
- Underrun: if RUN needs a pixel but the buffer is empty because rom_ok is late, output 0 for that pixel and set underrun=1. underrun clears only on reset. The fetch still completes, and pixel alignment resumes from the next received word.
- Simultaneous LHBL fall and cpu_we to the scroll registers: the new value is used, since the write takes precedence within the same clk.

Decomposition:
- Shared package jtvigil_pkg holds:
  - register offsets SCR2_SCRL_LO=0, SCR2_SCRL_HI=1, SCR2_CTRL=2;
  - CTRL bit positions: COL=[2:0], ENB=6;
  - the FSM state encoding.
- One sub-module, jtvigil_scr2_shift: 64-bit, two-word pixel shift buffer with load-lower, load-upper, shift and valid/empty flags. Everything else stays in the top module.

Test Plan:
- Reset: hold rst_n=0 mid-line with rom_cs=1 → all outputs 0 and FSM IDLE within the same clk; rom_cs stays 0 after release until the next LHBL fall.
- Scroll 0, v=9, row 10 word 0 = 32'h76543210, word 1 = 32'hFEDCBA98 → rom_addr 16'h0A00 then 16'h0A01; first 16 active pixels are 0,1,…,F.
- Scroll 11'h005 with the same data → first pixels 5,6,7,8; first fetch address 16'h0A00.
- Scroll 11'h7FC → second fetch column wraps: rom_addr 16'h0AFF then 16'h0A00; pixel order remains contiguous.
- Write scroll mid-line → current line unchanged; next line uses the new value. Write CTRL=8'h45 → scr2col=5 and scr2enb=1 on the next clk.
- Delay rom_ok 40 clk during RUN → affected pixels output 0 and underrun=1; later pixels are correct.
